// File: rtl/imem_stream_loader_if.sv
// Byte-stream input and instruction RAM byte write port of the loader.
// Stream: a byte moves on a rising edge when in_valid && in_ready; in_ready depends only on loader state.
interface imem_stream_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [7:0]            imem_wdata;

  // Stream source / RAM side.
  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Streams a length-prefixed program image into the instruction RAM and holds the core in reset meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte (state CHK).
module imem_stream_loader #(
  parameter int ADDR_WIDTH    = 8,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                clock,
  input  logic                reset,
  imem_stream_loader_if.slave bus,
  input  logic                load_start,
  output logic                core_reset,
  output logic                core_mem_en,
  output logic                load_done,
  output logic                load_err,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    HOLD   = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHK  = 3'd3
`endif
  } state_t;

  localparam int          DLY_W = (RELEASE_DELAY < 2) ? 1 : $clog2(RELEASE_DELAY);
  localparam logic [18:0] CAP   = 19'd1 << ADDR_WIDTH;

  state_t           state;
  logic [15:0]      word_count;
  logic [17:0]      byte_cnt;
  logic [DLY_W-1:0] dly;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  logic        xfer;
  logic        in_range;
  logic        data_last;
  logic [17:0] last_idx;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign last_idx  = {word_count, 2'b00} - 18'd1;
  assign data_last = (byte_cnt == last_idx);
  // Bytes past the RAM capacity are swallowed so the stream stays in sync.
  assign in_range  = ({1'b0, byte_cnt} < CAP);
  assign state_dbg = state;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.in_ready = (state == LEN_HI) || (state == LEN_LO) ||
                        (state == DATA)   || (state == CHK);
`else
  assign bus.in_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= LEN_HI;
      word_count     <= 16'd0;
      byte_cnt       <= 18'd0;
      dly            <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 8'd0;
      core_reset     <= 1'b1;
      core_mem_en    <= 1'b0;
      load_done      <= 1'b0;
      load_err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum           <= 8'd0;
`endif
    end else if (load_start) begin
      state       <= LEN_HI;
      word_count  <= 16'd0;
      byte_cnt    <= 18'd0;
      dly         <= '0;
      bus.imem_we <= 1'b0;
      core_reset  <= 1'b1;
      core_mem_en <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum        <= 8'd0;
`endif
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        LEN_HI: begin
          if (xfer) begin
            word_count[15:8] <= bus.in_data;
            state            <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            word_count[7:0] <= bus.in_data;
            byte_cnt        <= 18'd0;
            dly             <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum            <= 8'd0;
            state           <= ({word_count[15:8], bus.in_data} == 16'd0) ? CHK : DATA;
`else
            state           <= ({word_count[15:8], bus.in_data} == 16'd0) ? HOLD : DATA;
`endif
          end
        end
        DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 18'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.in_data;
`endif
            if (in_range) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= byte_cnt[ADDR_WIDTH-1:0];
              bus.imem_wdata <= bus.in_data;
            end else begin
              load_err <= 1'b1;
            end
            if (data_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state <= (load_err || !in_range) ? ERR : HOLD;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            if (load_err) begin
              state <= ERR;
            end else if (bus.in_data == csum) begin
              state <= HOLD;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end
`endif
        HOLD: begin
          // The final write cycle itself is not part of the release delay.
          if (!bus.imem_we) begin
            if (dly == DLY_W'(RELEASE_DELAY - 1)) begin
              state       <= RUN;
              core_reset  <= 1'b0;
              core_mem_en <= 1'b1;
              load_done   <= 1'b1;
            end else begin
              dly <= dly + 1'b1;
            end
          end
        end
        RUN: begin
          state <= RUN;
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= LEN_HI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader with a 16-byte RAM; expected writes kept in a queue.
module tb_imem_stream_loader;
  localparam int AW = 4;
  localparam int RD = 4;
  localparam logic [31:0] S_LEN_HI = 32'd0;
  localparam logic [31:0] S_HOLD   = 32'd4;
  localparam logic [31:0] S_RUN    = 32'd5;
  localparam logic [31:0] S_ERR    = 32'd6;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic       core_reset;
  logic       core_mem_en;
  logic       load_done;
  logic       load_err;
  logic [2:0] state_dbg;

  imem_stream_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_stream_loader #(.ADDR_WIDTH(AW), .RELEASE_DELAY(RD)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .load_start (load_start),
    .core_reset (core_reset),
    .core_mem_en(core_mem_en),
    .load_done  (load_done),
    .load_err   (load_err),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_we_cyc = 0;
  logic xfer_prev = 1'b0;
  logic [AW+7:0] exp_q[$];
  logic [AW+7:0] exp_e;
  logic [7:0]    prog2[8];

  always @(posedge clock) begin
    cyc       <= cyc + 1;
    xfer_prev <= bus.in_valid && bus.in_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every RAM write must be expected and follow a transfer by one cycle
  always @(negedge clock) begin
    if (bus.imem_we === 1'b1) begin
      last_we_cyc = cyc;
      chk("write_latency", 32'(xfer_prev), 32'd1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected no write",
               bus.imem_addr, bus.imem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        chk("write_addr", 32'(bus.imem_addr), 32'(exp_e[AW+7:8]));
        chk("write_data", 32'(bus.imem_wdata), 32'(exp_e[7:0]));
      end
    end
  end

  // drivers
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $error("FAIL send_timeout: observed in_ready %b expected 1", bus.in_ready);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b, input bit gap, input int addr, input bit wr);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    if (wr) exp_q.push_back({a, b});
    send_byte(b);
    if (gap) @(negedge clock);
  endtask

  task automatic send_tail(input logic [7:0] cs);
    if (CSUM) send_byte(cs);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    load_start = 1'b1;
    @(posedge clock);
    #1;
    load_start = 1'b0;
  endtask

  task automatic wait_release(output int rel);
    int n;
    n = 0;
    while (core_reset !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    rel = cyc;
    if (n >= 200) begin
      total++;
      bad++;
      $error("FAIL release_timeout: observed core_reset %b expected 0", core_reset);
    end
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd0);
    chk({tag, "_mem_en"}, 32'(core_mem_en), 32'd1);
    chk({tag, "_load_done"}, 32'(load_done), 32'd1);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_state"}, 32'(state_dbg), S_RUN);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int t0;
    bus.in_data  = 8'd0;
    bus.in_valid = 1'b0;
    prog2[0] = 8'h00; prog2[1] = 8'h00; prog2[2] = 8'h27; prog2[3] = 8'h83;
    prog2[4] = 8'h00; prog2[5] = 8'h17; prog2[6] = 8'h87; prog2[7] = 8'h93;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_mem_en", 32'(core_mem_en), 32'd0);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.imem_wdata), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_state", 32'(state_dbg), S_LEN_HI);

    // two-word program, valid held high; XOR of the data is A7
    send_byte(8'h00);
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) send_data(prog2[i], 1'b0, i, 1'b1);
    send_tail(8'hA7);
    chk("hold_core_reset", 32'(core_reset), 32'd1);
    chk("hold_mem_en", 32'(core_mem_en), 32'd0);
    chk("hold_ready", 32'(bus.in_ready), 32'd0);
    chk("hold_state", 32'(state_dbg), S_HOLD);
    wait_release(rel);
    chk("release_delay", 32'(rel - last_we_cyc), 32'(RD + 1));
    check_run("run1");
    chk("run1_drained", 32'(exp_q.size()), 32'd0);

    // reload from RUN, then bursty valid
    pulse_start();
    chk("reload_core_reset", 32'(core_reset), 32'd1);
    chk("reload_mem_en", 32'(core_mem_en), 32'd0);
    chk("reload_ready", 32'(bus.in_ready), 32'd1);
    chk("reload_done", 32'(load_done), 32'd0);
    chk("reload_state", 32'(state_dbg), S_LEN_HI);
    send_byte(8'h00);
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) send_data(prog2[i], 1'b1, i, 1'b1);
    send_tail(8'hA7);
    wait_release(rel);
    check_run("run2");
    chk("run2_drained", 32'(exp_q.size()), 32'd0);

    // zero length
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_tail(8'h00);
    t0 = cyc;
    wait_release(rel);
    chk("zero_release_delay", 32'(rel - t0), 32'(RD));
    check_run("run_zero");

    // overflow: 5 words into a 16-byte RAM
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h05);
    for (int i = 0; i < 20; i++) send_data(8'(8'hA0 + i), 1'b0, i, i < 16);
    send_tail(8'h00);
    @(negedge clock);
    chk("ovf_state", 32'(state_dbg), S_ERR);
    chk("ovf_err", 32'(load_err), 32'd1);
    chk("ovf_core_reset", 32'(core_reset), 32'd1);
    chk("ovf_mem_en", 32'(core_mem_en), 32'd0);
    chk("ovf_ready", 32'(bus.in_ready), 32'd0);
    repeat (RD + 4) @(negedge clock);
    chk("ovf_stays_reset", 32'(core_reset), 32'd1);
    chk("ovf_stays_err", 32'(state_dbg), S_ERR);
    chk("ovf_drained", 32'(exp_q.size()), 32'd0);
    pulse_start();
    chk("ovf_clear_state", 32'(state_dbg), S_LEN_HI);
    chk("ovf_clear_err", 32'(load_err), 32'd0);
    chk("ovf_clear_ready", 32'(bus.in_ready), 32'd1);

    // one-word load at address 0; XOR is 22
    send_byte(8'h00);
    send_byte(8'h01);
    send_data(8'hDE, 1'b0, 0, 1'b1);
    send_data(8'hAD, 1'b0, 1, 1'b1);
    send_data(8'hBE, 1'b0, 2, 1'b1);
    send_data(8'hEF, 1'b0, 3, 1'b1);
    send_tail(8'h22);
    wait_release(rel);
    check_run("run_one");
    chk("run_one_drained", 32'(exp_q.size()), 32'd0);

    // reset after three data bytes, coinciding with a fourth transfer
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_data(8'h11, 1'b0, 0, 1'b1);
    send_data(8'h22, 1'b0, 1, 1'b1);
    send_data(8'h33, 1'b0, 2, 1'b1);
    @(negedge clock);
    reset        = 1'b1;
    bus.in_data  = 8'h44;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_we", 32'(bus.imem_we), 32'd0);
    chk("abort_state", 32'(state_dbg), S_LEN_HI);
    chk("abort_core_reset", 32'(core_reset), 32'd1);
    chk("abort_addr", 32'(bus.imem_addr), 32'd0);
    chk("abort_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_drained", 32'(exp_q.size()), 32'd0);

    // checksum pass (08) and fail (09)
    if (CSUM) begin
      send_byte(8'h00);
      send_byte(8'h01);
      send_data(8'h12, 1'b0, 0, 1'b1);
      send_data(8'h34, 1'b0, 1, 1'b1);
      send_data(8'h56, 1'b0, 2, 1'b1);
      send_data(8'h78, 1'b0, 3, 1'b1);
      send_byte(8'h08);
      wait_release(rel);
      check_run("csum_ok");
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h01);
      send_data(8'h12, 1'b0, 0, 1'b1);
      send_data(8'h34, 1'b0, 1, 1'b1);
      send_data(8'h56, 1'b0, 2, 1'b1);
      send_data(8'h78, 1'b0, 3, 1'b1);
      send_byte(8'h09);
      @(negedge clock);
      chk("csum_bad_state", 32'(state_dbg), S_ERR);
      chk("csum_bad_err", 32'(load_err), 32'd1);
      chk("csum_bad_core_reset", 32'(core_reset), 32'd1);
      pulse_start();
    end

    repeat (2) @(negedge clock);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
